// File: rtl/demux_pkg.sv
// Shared sizes, state encoding and helpers for the 1-to-1024 registered demultiplexer.
package demux_pkg;

  localparam int N  = 1024;
  localparam int SW = $clog2(N);

  // Frame counter holds 0..N, so the last write of a frame is seen at N-1.
  localparam logic [SW:0] CNT_LAST = (SW+1)'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } demux_state_t;

  function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/demux1024_reg_if.sv
// Write-side bus of demux1024_reg: data/address/control in, output bank and status out.
interface demux1024_reg_if;
  import demux_pkg::*;

  logic          d;
  logic [SW-1:0] s;
  logic          wr_en;
  logic          auto;
  logic          start;
  logic          clr;
  logic [N-1:0]  o;
  logic          busy;
  logic          done;
  logic [SW-1:0] wr_ptr;

  modport master (
    output d, s, wr_en, auto, start, clr,
    input  o, busy, done, wr_ptr
  );

  modport slave (
    input  d, s, wr_en, auto, start, clr,
    output o, busy, done, wr_ptr
  );

endinterface

// File: rtl/demux_dec.sv
// SW-to-N one-hot decoder with enable; yields per-bit write enables for the output bank.
module demux_dec #(
  parameter int SW = 10,
  parameter int N  = 1 << SW
) (
  input  logic          en,
  input  logic [SW-1:0] addr,
  output logic [N-1:0]  onehot
);

  always_comb begin
    // NOTE: the all-zero default comes first so every path assigns onehot and no latch is inferred.
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/demux1024_reg.sv
// Registered 1-to-1024 demultiplexer with direct and auto-fill (wrapping frame) addressing.
module demux1024_reg
  import demux_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  demux1024_reg_if.slave  bus
);

  demux_state_t  state;
  logic [SW:0]   cnt;
  logic [SW-1:0] wr_ptr_q;
  logic [N-1:0]  o_q;
  logic          busy_q;
  logic          done_q;

  logic          start_take;
  logic          fill_wr;
  logic          direct_wr;
  logic          bank_we;
  logic [SW-1:0] wr_addr;
  logic [N-1:0]  bit_en;

  // A start only takes effect outside a frame; when it does, it swallows any same-cycle write.
  assign start_take = bus.start & bus.auto & (state != FILL);
  assign fill_wr    = bus.wr_en & (state == FILL);
  assign direct_wr  = bus.wr_en & ~bus.auto & (state != FILL) & ~start_take;
  assign bank_we    = ~bus.clr & (fill_wr | direct_wr);
  assign wr_addr    = (state == FILL) ? wr_ptr_q : bus.s;

  demux_dec #(
    .SW (SW),
    .N  (N)
  ) u_dec (
    .en     (bank_we),
    .addr   (wr_addr),
    .onehot (bit_en)
  );

  // NOTE: the bank is built from flops, not RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
    end else if (bus.clr) begin
      o_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      o_q <= (o_q & ~bit_en) | (bit_en & {N{bus.d}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.clr) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_take) begin
            state    <= FILL;
            wr_ptr_q <= bus.s;
            cnt      <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        FILL: begin
          // auto and start are deliberately not looked at here: a frame runs to its N-th write.
          if (bus.wr_en) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            cnt      <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o      = o_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.wr_ptr = wr_ptr_q;

endmodule

// File: tb/tb_demux1024_reg.sv
// Self-checking bench for demux1024_reg: directed scenarios plus a randomized mix against a frame-level model.
module tb_demux1024_reg;
  import demux_pkg::*;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux1024_reg_if bus ();

  demux1024_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the bank as a bit array, the frame as mode/pointer/writes-so-far.
  logic [N-1:0] m_o;
  int m_mode;
  int m_ptr;
  int m_cnt;

  task automatic model_reset();
    m_o = '0;
    m_mode = M_IDLE;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    if (bus.clr) begin
      model_reset();
    end else if (bus.start && bus.auto && m_mode != M_FILL) begin
      m_mode = M_FILL;
      m_ptr = int'(bus.s);
      m_cnt = 0;
    end else if (bus.wr_en) begin
      if (m_mode == M_FILL) begin
        m_o[m_ptr] = bus.d;
        m_ptr = (m_ptr + 1) % N;
        m_cnt = m_cnt + 1;
        if (m_cnt == N) m_mode = M_DONE;
      end else if (!bus.auto) begin
        m_o[bus.s] = bus.d;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.d = 1'b0;
    bus.s = '0;
    bus.wr_en = 1'b0;
    bus.auto = 1'b0;
    bus.start = 1'b0;
    bus.clr = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = 0; i < N; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic start_frame(input int addr);
    bus.auto = 1'b1;
    bus.s = SW'(addr);
    bus.start = 1'b1;
    bus.wr_en = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    tests++;
    if (bus.o !== '0) begin
      fails++;
      $display("FAIL reset_o: bit %0d set, want all zero", first_diff(bus.o, '0));
    end
    tests++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.wr_ptr !== '0) begin
      fails++;
      $display("FAIL reset_status: busy=%b done=%b wr_ptr=%0d, want 0 0 0", bus.busy, bus.done, bus.wr_ptr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    int addrs[5] = '{0, 10, 123, 512, 1023};
    for (int k = 0; k < 5; k++) begin
      bus.auto = 1'b0;
      bus.s = SW'(addrs[k]);
      bus.d = 1'b1;
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      tests++;
      if (bus.o[addrs[k]] !== 1'b1) begin
        fails++;
        $display("FAIL direct_write: o[%0d]=%b one cycle after write, want 1", addrs[k], bus.o[addrs[k]]);
      end
    end
    tests++;
    if ($countones(bus.o) != 5 || bus.o !== m_o) begin
      fails++;
      $display("FAIL direct_bank: %0d bits set, want 5 (first diff bit %0d)", $countones(bus.o), first_diff(bus.o, m_o));
    end
    // Loopback through a mux1024 behaving as o[s].
    for (int k = 0; k < 5; k++) begin
      bus.s = SW'(addrs[k]);
      #1;
      tests++;
      if (bus.o[bus.s] !== 1'b1) begin
        fails++;
        $display("FAIL loopback: mux(o, s=%0d)=%b, want 1", addrs[k], bus.o[bus.s]);
      end
    end
    bus.s = SW'(11);
    #1;
    tests++;
    if (bus.o[bus.s] !== 1'b0) begin
      fails++;
      $display("FAIL loopback_unwritten: mux(o, s=11)=%b, want 0", bus.o[bus.s]);
    end
    do_clear();
  endtask

  task automatic test_auto_frame();
    logic [N-1:0] exp;
    for (int k = 0; k < N; k++) exp[k] = k[0];
    start_frame(0);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL auto_busy: busy=%b after start, want 1", bus.busy);
    end
    for (int i = 0; i < N; i++) begin
      bus.wr_en = 1'b1;
      bus.d = i[0];
      tick();
      if (i == N - 2) begin
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL auto_early_done: after write %0d done=%b busy=%b, want 0 1", i + 1, bus.done, bus.busy);
        end
      end
    end
    bus.wr_en = 1'b0;
    tests++;
    if (bus.o !== exp) begin
      fails++;
      $display("FAIL auto_bank: first wrong bit %0d, got %b want %b", first_diff(bus.o, exp),
               bus.o[first_diff(bus.o, exp)], exp[first_diff(bus.o, exp)]);
    end
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ptr !== SW'(0)) begin
      fails++;
      $display("FAIL auto_end: done=%b busy=%b wr_ptr=%0d, want 1 0 0", bus.done, bus.busy, bus.wr_ptr);
    end
    do_clear();
  endtask

  task automatic test_wrap();
    int writes = 0;
    int cyc = 0;
    start_frame(1000);
    while (writes < N && cyc < 4000) begin
      bus.wr_en = (cyc % 3 != 2);
      bus.d = 1'b1;
      tick();
      if (bus.wr_en) writes++;
      cyc++;
    end
    bus.wr_en = 1'b0;
    tests++;
    if (writes != N || cyc <= N) begin
      fails++;
      $display("FAIL wrap_budget: %0d writes in %0d cycles, want %0d writes in more than %0d cycles", writes, cyc, N, N);
    end
    tests++;
    if (bus.o !== {N{1'b1}}) begin
      fails++;
      $display("FAIL wrap_bank: bit %0d clear, want all ones", first_diff(bus.o, {N{1'b1}}));
    end
    tests++;
    if (bus.wr_ptr !== SW'(1000) || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL wrap_end: wr_ptr=%0d done=%b, want 1000 1", bus.wr_ptr, bus.done);
    end
    do_clear();
  endtask

  task automatic test_conflicts();
    // clr beats a same-cycle direct write.
    bus.auto = 1'b0; bus.s = SW'(5); bus.d = 1'b1; bus.wr_en = 1'b1;
    tick();
    bus.clr = 1'b1;
    tick();
    idle_inputs();
    tests++;
    if (bus.o !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL clr_vs_write: o bit %0d set busy=%b done=%b, want clear idle", first_diff(bus.o, '0), bus.busy, bus.done);
    end
    // start during FILL leaves the frame position alone.
    start_frame(0);
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = 1'b1; bus.d = 1'b0;
      tick();
    end
    bus.wr_en = 1'b0; bus.start = 1'b1; bus.s = SW'(77);
    tick();
    tests++;
    if (bus.wr_ptr !== SW'(10) || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL start_in_fill: wr_ptr=%0d busy=%b, want 10 1", bus.wr_ptr, bus.busy);
    end
    bus.wr_en = 1'b1; bus.d = 1'b1;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    tests++;
    if (bus.wr_ptr !== SW'(11) || bus.o[10] !== 1'b1 || bus.o[77] !== 1'b0) begin
      fails++;
      $display("FAIL start_wr_in_fill: wr_ptr=%0d o[10]=%b o[77]=%b, want 11 1 0", bus.wr_ptr, bus.o[10], bus.o[77]);
    end
    // Direct write attempt mid-frame does not reach o[s].
    bus.auto = 1'b0; bus.s = SW'(900); bus.d = 1'b1; bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.auto = 1'b1;
    tests++;
    if (bus.o[900] !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL direct_in_fill: o[900]=%b busy=%b, want 0 1", bus.o[900], bus.busy);
    end
    do_clear();
    // start and wr_en together in IDLE: the write is dropped, the frame begins at s.
    bus.auto = 1'b1; bus.start = 1'b1; bus.wr_en = 1'b1; bus.s = SW'(20); bus.d = 1'b1;
    tick();
    idle_inputs();
    tests++;
    if (bus.o[20] !== 1'b0 || bus.busy !== 1'b1 || bus.wr_ptr !== SW'(20)) begin
      fails++;
      $display("FAIL start_vs_write: o[20]=%b busy=%b wr_ptr=%0d, want 0 1 20", bus.o[20], bus.busy, bus.wr_ptr);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    start_frame(0);
    for (int i = 0; i < 299; i++) begin
      bus.wr_en = 1'b1; bus.d = 1'b1;
      tick();
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (bus.o !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_ptr !== '0) begin
      fails++;
      $display("FAIL async_reset: o bit %0d busy=%b done=%b wr_ptr=%0d, want all zero",
               first_diff(bus.o, '0), bus.busy, bus.done, bus.wr_ptr);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    start_frame(0);
    for (int i = 0; i < N; i++) begin
      bus.wr_en = 1'b1; bus.d = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    tests++;
    if (bus.o !== {N{1'b1}} || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL fresh_frame: bit %0d clear done=%b busy=%b, want all ones 1 0",
               first_diff(bus.o, {N{1'b1}}), bus.done, bus.busy);
    end
    do_clear();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 999));
      bus.clr = (r < 1);
      bus.start = (r >= 1 && r < 40);
      bus.auto = (m_mode == M_FILL) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.wr_en = ($urandom_range(0, 99) < 75);
      bus.d = 1'($urandom_range(0, 1));
      bus.s = SW'($urandom_range(0, N - 1));
      tick();
      tests++;
      if (bus.o !== m_o || bus.busy !== (m_mode == M_FILL) || bus.done !== (m_mode == M_DONE) ||
          bus.wr_ptr !== SW'(m_ptr)) begin
        fails++;
        $display("FAIL random_op%0d: diff bit %0d busy=%b done=%b wr_ptr=%0d, want mode %0d ptr %0d",
                 n, first_diff(bus.o, m_o), bus.busy, bus.done, bus.wr_ptr, m_mode, m_ptr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_direct();
    test_auto_frame();
    test_wrap();
    test_conflicts();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
